reg_rename_file: RTL and testbench
==================================

# reg_rename_file

Parametrised architectural register file with rename tracking for the out-of-order core. It generalises the two-port register/dependency table to N read ports, configurable register count, XLEN and RoB tag width. It adds an explicit issue/commit valid, whole-table flush on misprediction, and x0 hardening. It sits between Decoder (read ports, issue) and RoB (commit, tag value query).

## Interface
- `NUM_REGS`, default 32: architectural registers; index width `IDX_W = $clog2(NUM_REGS)`.
- `XLEN`, default 32: data width.
- `ROB_W`, default `ROB_SIZE_WIDTH`: RoB tag width.
- `NUM_RD`, default 2: read ports.
- `clk` in 1: clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rdy` in 1: global enable; low freezes all state.
- `flush` in 1: misprediction clear.
- `issue_en` in 1: rename valid.
- `issue_rd` in IDX_W: rename destination.
- `issue_rob_id` in ROB_W: rename tag.
- `commit_en` in 1: commit valid.
- `commit_rd` in IDX_W: commit destination.
- `commit_rob_id` in ROB_W: commit tag.
- `commit_value` in XLEN: commit data.
- `rd_idx` in NUM_RD*IDX_W: read indices, port p at `[p*IDX_W +: IDX_W]`; same packing for all flattened buses.
- `rd_value` out NUM_RD*XLEN: operand value.
- `rd_busy` out NUM_RD: operand not yet available.
- `rd_rob_id` out NUM_RD*ROB_W: producer tag (valid when `rd_busy`).
- `rob_qry_id` out NUM_RD*ROB_W: tag sent to RoB for value lookup.
- `rob_qry_value` in NUM_RD*XLEN: RoB value for queried tag.
- `rob_qry_ready` in NUM_RD: RoB entry has result.

## Operation
- State: `regs[NUM_REGS]` (XLEN), `busy[NUM_REGS]`, `tag[NUM_REGS]` (ROB_W).
- Reset (`rst_n`=0, immediate): all regs, busy, tags 0. All outputs combinational; after reset `rd_value`=0, `rd_busy`=0, `rd_rob_id`=0, `rob_qry_id`=0.
- Read port p, r=`rd_idx[p]`:
  - `iss_hit` = `issue_en & !flush & issue_rd==r & r!=0`.
  - `dep` = `iss_hit | busy[r]`.
  - `rd_rob_id` = `iss_hit ? issue_rob_id : tag[r]`; `rob_qry_id` equals it.
  - `rd_busy` = `dep & !rob_qry_ready[p]`.
  - `rd_value` = `dep ? rob_qry_value[p] : regs[r]`.
  - r=0: value 0, busy 0, tag 0, regardless of inputs.
- Update, only when `rdy`=1 (priority top-down):
  - Commit: if `commit_en & commit_rd!=0`, write `regs[commit_rd]`. If `busy[commit_rd] & tag[commit_rd]==commit_rob_id`, clear `busy` and set `tag`=0. A tag mismatch leaves busy set, because a younger rename is pending.
  - Issue: if `issue_en & issue_rd!=0 & !flush`, set `busy[issue_rd]`=1 and `tag`=`issue_rob_id`. This overrides a same-cycle commit clear on the same register.
  - Flush: all `busy`=0, all `tag`=0. The same-cycle commit value write still happens; the same-cycle issue is dropped.
- `regs[0]` is never written; `busy[0]` is never set.

## Timing
- Reads: zero latency, combinational through the RoB query loop. The RoB must answer within the same cycle.
- Issue is visible to reads in the same cycle (bypass) and from table state on the next edge.
- Commit value is visible from `regs` the next cycle. In the commit cycle, a read sees the value via the RoB query (entry still valid) or via the bypass (see Configuration).
- `rdy`=0: reads still evaluate; no state changes, including flush and commit.
- Reset mid-operation discards all pending renames; no output glitch beyond the async clear.

## Configuration
- `REG_COMMIT_BYPASS_EN` defined: the read path adds a third source, consulted before the RoB query result. Condition: `commit_en & commit_rd==r & r!=0 & !iss_hit & busy[r] & tag[r]==commit_rob_id`. Effect: `rd_value`=`commit_value`, `rd_busy`=0.
- Undefined: no commit bypass; the commit-cycle read relies solely on `rob_qry_ready`.

## Structure
- Shared config header/package: `ROB_SIZE_WIDTH`, default `NUM_REGS`/`XLEN`, `IDX_W` derivation, `REG_COMMIT_BYPASS_EN` placement.
- Sub-module `reg_read_port`: one instance per port via generate, containing the combinational mux and bypass logic. Inputs are that port's index, table entry, issue/commit buses and RoB query.
- Top level holds the tables and update logic.

## Test plan
- Reset: hold `rst_n`=0 mid-run with busy entries, then release → all ports read x5: value 0, busy 0, tag 0.
- Issue x5 tag 3, read x5 same cycle → busy=1, rob_id=3, `rob_qry_id`=3. Next cycle `rob_qry_ready`=1, `rob_qry_value`=0x55 → busy=0, value 0x55.
- Issue x7 tag 2, then x7 tag 4, then commit x7 tag 2 value 0xAA → `regs[7]`=0xAA, busy stays 1 with tag 4. Commit tag 4 value 0xBB → busy 0, read 0xBB.
- Same cycle: commit x9 tag 1 (busy, tag 1) and issue x9 tag 6 → next cycle busy=1, tag 6, `regs[9]`=commit value.
- Flush with x3/x4 busy, plus same-cycle issue x8 tag 5 and commit x3 value 0x12 → all busy 0, x8 not busy, `regs[3]`=0x12.
- Issue/commit to x0 with value 0xFFFF, and `rdy`=0 with issue x6 → x0 reads 0, not busy; x6 unchanged.

Source files
------------

// File: rtl/reg_rename_file_pkg.sv
// Shared configuration for the rename-tracking register file.
// The optional commit bypass is enabled by defining REG_COMMIT_BYPASS_EN.
package reg_rename_file_pkg;

  localparam int ROB_SIZE_WIDTH   = 4;
  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_XLEN     = 32;

  function automatic int idx_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/reg_rename_file_read_port.sv
// One combinational operand read port: issue bypass, RoB query mux and x0 hardening.
// With REG_COMMIT_BYPASS_EN defined, a matching same-cycle commit also forwards its value.
module reg_read_port
  import reg_rename_file_pkg::*;
#(
  parameter int IDX_W = 5,
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int ROB_W = ROB_SIZE_WIDTH
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [XLEN-1:0]  entry_value,
  input  logic             entry_busy,
  input  logic [ROB_W-1:0] entry_tag,
  input  logic             flush,
  input  logic             issue_en,
  input  logic [IDX_W-1:0] issue_rd,
  input  logic [ROB_W-1:0] issue_rob_id,
  input  logic             commit_en,
  input  logic [IDX_W-1:0] commit_rd,
  input  logic [ROB_W-1:0] commit_rob_id,
  input  logic [XLEN-1:0]  commit_value,
  input  logic [XLEN-1:0]  qry_value,
  input  logic             qry_ready,
  output logic [XLEN-1:0]  rd_value,
  output logic             rd_busy,
  output logic [ROB_W-1:0] rd_rob_id,
  output logic [ROB_W-1:0] rob_qry_id
);

  logic iss_hit;
  logic dep;
  logic cmt_hit;

`ifdef REG_COMMIT_BYPASS_EN
  // Only the commit that retires the current producer may forward; a younger rename wins.
  assign cmt_hit = commit_en && (commit_rd == idx) && (idx != '0) && !iss_hit &&
                   entry_busy && (entry_tag == commit_rob_id);
`else
  logic unused_commit;
  assign cmt_hit       = 1'b0;
  assign unused_commit = ^{commit_en, commit_rd, commit_rob_id, commit_value};
`endif

  assign iss_hit = issue_en && !flush && (issue_rd == idx) && (idx != '0);
  assign dep     = iss_hit || entry_busy;

  always_comb begin
    rd_value  = cmt_hit ? commit_value : (dep ? qry_value : entry_value);
    rd_busy   = dep && !qry_ready && !cmt_hit;
    rd_rob_id = iss_hit ? issue_rob_id : entry_tag;
    if (idx == '0) begin
      rd_value  = '0;
      rd_busy   = 1'b0;
      rd_rob_id = '0;
    end
  end

  assign rob_qry_id = rd_rob_id;

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename tag tracking, N read ports.
// Optional same-cycle commit forwarding on the read ports: define REG_COMMIT_BYPASS_EN.
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter int  NUM_REGS = DEFAULT_NUM_REGS,
  parameter int  XLEN     = DEFAULT_XLEN,
  parameter int  ROB_W    = ROB_SIZE_WIDTH,
  parameter int  NUM_RD   = 2,
  localparam int IDX_W    = idx_width(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    issue_en,
  input  logic [IDX_W-1:0]        issue_rd,
  input  logic [ROB_W-1:0]        issue_rob_id,
  input  logic                    commit_en,
  input  logic [IDX_W-1:0]        commit_rd,
  input  logic [ROB_W-1:0]        commit_rob_id,
  input  logic [XLEN-1:0]         commit_value,
  input  logic [NUM_RD*IDX_W-1:0] rd_idx,
  output logic [NUM_RD*XLEN-1:0]  rd_value,
  output logic [NUM_RD-1:0]       rd_busy,
  output logic [NUM_RD*ROB_W-1:0] rd_rob_id,
  output logic [NUM_RD*ROB_W-1:0] rob_qry_id,
  input  logic [NUM_RD*XLEN-1:0]  rob_qry_value,
  input  logic [NUM_RD-1:0]       rob_qry_ready
);

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [XLEN-1:0]     regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [ROB_W-1:0]    tag_q  [NUM_REGS];
  logic [ROB_W-1:0]    tag_d  [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  // Later assignments take precedence: issue overrides a commit clear, flush overrides both.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy) begin
      if (commit_en && (commit_rd != '0)) begin
        regs_d[commit_rd] = commit_value;
        if (busy_q[commit_rd] && (tag_q[commit_rd] == commit_rob_id)) begin
          busy_d[commit_rd] = 1'b0;
          tag_d[commit_rd]  = '0;
        end
      end
      if (issue_en && (issue_rd != '0) && !flush) begin
        busy_d[issue_rd] = 1'b1;
        tag_d[issue_rd]  = issue_rob_id;
      end
      if (flush) begin
        busy_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
          tag_d[i] = '0;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [IDX_W-1:0] idx;
    assign idx = rd_idx[gi*IDX_W +: IDX_W];

    reg_read_port #(
      .IDX_W (IDX_W),
      .XLEN  (XLEN),
      .ROB_W (ROB_W)
    ) u_port (
      .idx           (idx),
      .entry_value   (regs_q[idx]),
      .entry_busy    (busy_q[idx]),
      .entry_tag     (tag_q[idx]),
      .flush         (flush),
      .issue_en      (issue_en),
      .issue_rd      (issue_rd),
      .issue_rob_id  (issue_rob_id),
      .commit_en     (commit_en),
      .commit_rd     (commit_rd),
      .commit_rob_id (commit_rob_id),
      .commit_value  (commit_value),
      .qry_value     (rob_qry_value[gi*XLEN +: XLEN]),
      .qry_ready     (rob_qry_ready[gi]),
      .rd_value      (rd_value[gi*XLEN +: XLEN]),
      .rd_busy       (rd_busy[gi]),
      .rd_rob_id     (rd_rob_id[gi*ROB_W +: ROB_W]),
      .rob_qry_id    (rob_qry_id[gi*ROB_W +: ROB_W])
    );
  end

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file (default build, two read ports, 32 regs, 4-bit tags).
module tb_reg_rename_file;

  localparam int IDX_W = 5;
  localparam int XLEN  = 32;
  localparam int ROB_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rdy;
  logic              flush;
  logic              issue_en;
  logic [IDX_W-1:0]  issue_rd;
  logic [ROB_W-1:0]  issue_rob_id;
  logic              commit_en;
  logic [IDX_W-1:0]  commit_rd;
  logic [ROB_W-1:0]  commit_rob_id;
  logic [XLEN-1:0]   commit_value;
  logic [2*IDX_W-1:0] rd_idx;
  logic [2*XLEN-1:0] rd_value;
  logic [1:0]        rd_busy;
  logic [2*ROB_W-1:0] rd_rob_id;
  logic [2*ROB_W-1:0] rob_qry_id;
  logic [2*XLEN-1:0] rob_qry_value;
  logic [1:0]        rob_qry_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_rename_file dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rdy           (rdy),
    .flush         (flush),
    .issue_en      (issue_en),
    .issue_rd      (issue_rd),
    .issue_rob_id  (issue_rob_id),
    .commit_en     (commit_en),
    .commit_rd     (commit_rd),
    .commit_rob_id (commit_rob_id),
    .commit_value  (commit_value),
    .rd_idx        (rd_idx),
    .rd_value      (rd_value),
    .rd_busy       (rd_busy),
    .rd_rob_id     (rd_rob_id),
    .rob_qry_id    (rob_qry_id),
    .rob_qry_value (rob_qry_value),
    .rob_qry_ready (rob_qry_ready)
  );

  wire [XLEN-1:0]  val0 = rd_value[XLEN-1:0];
  wire [XLEN-1:0]  val1 = rd_value[2*XLEN-1:XLEN];
  wire [ROB_W-1:0] tag0 = rd_rob_id[ROB_W-1:0];
  wire [ROB_W-1:0] tag1 = rd_rob_id[2*ROB_W-1:ROB_W];
  wire [ROB_W-1:0] qid0 = rob_qry_id[ROB_W-1:0];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    flush         = 1'b0;
    issue_en      = 1'b0;
    issue_rd      = '0;
    issue_rob_id  = '0;
    commit_en     = 1'b0;
    commit_rd     = '0;
    commit_rob_id = '0;
    commit_value  = '0;
    rob_qry_ready = 2'b00;
    rob_qry_value = {32'hDEAD_0001, 32'hDEAD_0000};
  endtask

  task automatic read2(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
    rd_idx = {b, a};
  endtask

  task automatic issue(input logic [IDX_W-1:0] r, input logic [ROB_W-1:0] t);
    issue_en = 1'b1; issue_rd = r; issue_rob_id = t;
  endtask

  task automatic commit(input logic [IDX_W-1:0] r, input logic [ROB_W-1:0] t, input logic [XLEN-1:0] v);
    commit_en = 1'b1; commit_rd = r; commit_rob_id = t; commit_value = v;
  endtask

  initial begin
    rst_n = 1'b0;
    rdy   = 1'b1;
    idle();
    read2(5'd5, 5'd0);
    tick(); tick();
    #1;
    chk("reset_val", 32'(val0), 32'h0);
    chk("reset_busy", 32'(rd_busy[0]), 32'h0);
    chk("reset_tag", 32'(tag0), 32'h0);
    chk("reset_qid", 32'(qid0), 32'h0);
    tick();
    rst_n = 1'b1;

    // Issue x5 tag 3 seen through the bypass, then answered by the RoB.
    tick();
    issue(5'd5, 4'd3); read2(5'd5, 5'd5); #1;
    chk("iss_byp_busy", 32'(rd_busy[0]), 32'h1);
    chk("iss_byp_tag", 32'(tag0), 32'h3);
    chk("iss_byp_qid", 32'(qid0), 32'h3);
    tick();
    idle(); #1;
    chk("iss_tbl_busy", 32'(rd_busy[1]), 32'h1);
    chk("iss_tbl_tag", 32'(tag1), 32'h3);
    rob_qry_ready = 2'b01; rob_qry_value[31:0] = 32'h55; #1;
    chk("rob_ready_busy", 32'(rd_busy[0]), 32'h0);
    chk("rob_ready_val", 32'(val0), 32'h55);
    chk("rob_notready_p1", 32'(rd_busy[1]), 32'h1);

    // Double rename of x7; stale commit keeps it busy with the younger tag.
    tick(); idle(); issue(5'd7, 4'd2);
    tick(); idle(); issue(5'd7, 4'd4);
    tick(); idle(); commit(5'd7, 4'd2, 32'hAA);
    tick(); idle(); read2(5'd7, 5'd7); #1;
    chk("stale_cmt_busy", 32'(rd_busy[0]), 32'h1);
    chk("stale_cmt_tag", 32'(tag0), 32'h4);
    commit(5'd7, 4'd4, 32'hBB);
    tick(); idle(); #1;
    chk("final_cmt_busy", 32'(rd_busy[0]), 32'h0);
    chk("final_cmt_val", 32'(val0), 32'hBB);
    chk("final_cmt_tag", 32'(tag0), 32'h0);

    // Same-cycle commit and re-issue on x9.
    issue(5'd9, 4'd1);
    tick(); idle(); commit(5'd9, 4'd1, 32'h99); issue(5'd9, 4'd6);
    tick(); idle(); read2(5'd9, 5'd9); #1;
    chk("cmt_iss_busy", 32'(rd_busy[0]), 32'h1);
    chk("cmt_iss_tag", 32'(tag0), 32'h6);

    // Flush with x3/x4 busy, dropping a same-cycle issue and keeping the commit write.
    issue(5'd3, 4'd1);
    tick(); idle(); issue(5'd4, 4'd2);
    tick(); idle();
    flush = 1'b1; issue(5'd8, 4'd5); commit(5'd3, 4'd1, 32'h12); read2(5'd8, 5'd3); #1;
    chk("flush_cyc_x8_busy", 32'(rd_busy[0]), 32'h0);
    chk("flush_cyc_x8_tag", 32'(tag0), 32'h0);
    tick(); idle(); read2(5'd3, 5'd4); #1;
    chk("flush_x3_val", 32'(val0), 32'h12);
    chk("flush_x3_busy", 32'(rd_busy[0]), 32'h0);
    chk("flush_x4_busy", 32'(rd_busy[1]), 32'h0);
    chk("flush_x4_val", 32'(val1), 32'h0);
    read2(5'd8, 5'd9); #1;
    chk("flush_x8_busy", 32'(rd_busy[0]), 32'h0);
    chk("flush_x8_tag", 32'(tag0), 32'h0);
    chk("flush_x9_val", 32'(val1), 32'h99);
    chk("flush_x9_busy", 32'(rd_busy[1]), 32'h0);

    // x0 hardening.
    issue(5'd0, 4'd7); commit(5'd0, 4'd0, 32'hFFFF); read2(5'd0, 5'd0);
    rob_qry_value = {32'hBEEF, 32'hBEEF}; #1;
    chk("x0_cyc_val", 32'(val0), 32'h0);
    chk("x0_cyc_busy", 32'(rd_busy[0]), 32'h0);
    chk("x0_cyc_tag", 32'(tag0), 32'h0);
    tick(); idle(); #1;
    chk("x0_after_val", 32'(val1), 32'h0);
    chk("x0_after_busy", 32'(rd_busy[1]), 32'h0);

    // rdy low: reads evaluate, state frozen.
    rdy = 1'b0; issue(5'd6, 4'd3); commit(5'd10, 4'd0, 32'h66); read2(5'd6, 5'd6); #1;
    chk("rdy0_byp_busy", 32'(rd_busy[0]), 32'h1);
    chk("rdy0_byp_tag", 32'(tag0), 32'h3);
    tick(); idle(); rdy = 1'b1; read2(5'd6, 5'd10); #1;
    chk("rdy0_x6_busy", 32'(rd_busy[0]), 32'h0);
    chk("rdy0_x6_tag", 32'(tag0), 32'h0);
    chk("rdy0_x10_val", 32'(val1), 32'h0);

    // Asynchronous reset mid-cycle with a pending rename.
    issue(5'd5, 4'd3);
    tick(); idle(); commit(5'd10, 4'd0, 32'h77);
    tick(); idle(); read2(5'd5, 5'd10); #1;
    chk("pre_rst_busy", 32'(rd_busy[0]), 32'h1);
    chk("pre_rst_val", 32'(val1), 32'h77);
    #2 rst_n = 1'b0; #1;
    chk("async_rst_busy", 32'(rd_busy[0]), 32'h0);
    chk("async_rst_qid", 32'(qid0), 32'h0);
    chk("async_rst_val", 32'(val1), 32'h0);
    tick(); rst_n = 1'b1;
    tick(); #1;
    chk("post_rst_busy", 32'(rd_busy[0]), 32'h0);
    chk("post_rst_tag", 32'(tag0), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
